// File: rtl/add_arbiter_pkg.sv
// rtl/add_arbiter_pkg.sv - shared constants and FSM state type for the arbitrated adder
package add_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } state_e;

endpackage

// File: rtl/add_cba_adder.sv
// rtl/add_cba_adder.sv - 32-bit carry-bypass adder, 4-bit ripple blocks with block-propagate skip
module add_cba_adder
   import add_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cin_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              cout_o
);

   localparam int BLK  = 4;
   localparam int NBLK = DATA_W / BLK;

   logic [DATA_W-1:0] p;
   logic              c;
   logic              c_blk;
   logic              rc;

   assign p = a_i ^ b_i;

   // When every bit of a block propagates, its carry-out is its carry-in.
   always_comb begin
      sum_o = '0;
      c     = cin_i;
      c_blk = 1'b0;
      rc    = 1'b0;
      for (int j = 0; j < NBLK; j++) begin
         c_blk = c;
         rc    = c;
         for (int i = 0; i < BLK; i++) begin
            sum_o[j*BLK+i] = p[j*BLK+i] ^ rc;
            rc = (a_i[j*BLK+i] & b_i[j*BLK+i]) | (rc & p[j*BLK+i]);
         end
         c = (&p[j*BLK +: BLK]) ? c_blk : rc;
      end
   end

   assign cout_o = c;

endmodule

// File: rtl/add_rr_arbiter.sv
// rtl/add_rr_arbiter.sv - round-robin search starting at ptr_i, one-hot grant plus index
module add_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 3
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  gnt_id_o,
   output logic             gnt_valid_o
);

   int idx;

   always_comb begin
      gnt_o       = '0;
      gnt_id_o    = '0;
      gnt_valid_o = 1'b0;
      idx         = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr_i) + k) % N_REQ;
         if (!gnt_valid_o && req_i[idx]) begin
            gnt_valid_o = 1'b1;
            gnt_o[idx]  = 1'b1;
            gnt_id_o    = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - N requesters share one adder behind a one-entry result register
// Optional ADD_ARBITER_SAT_EN: saturate rsp_sum on signed overflow.
module add_arbiter
   import add_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [DATA_W*N_REQ-1:0] req_a,
   input  logic [DATA_W*N_REQ-1:0] req_b,
   input  logic [N_REQ-1:0]        req_cin,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_sum,
   output logic                    rsp_cout,
   output logic                    rsp_ovf
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q;
   logic [DATA_W-1:0] sum_q;
   logic              cout_q, ovf_q;

   logic              can_grant;
   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_id;
   logic              gnt_valid;
   logic [DATA_W-1:0] a_sel, b_sel, add_sum, sum_fin;
   logic              cin_sel, add_cout, add_ovf;

   // A held result must leave in the same cycle a new one is captured.
   assign can_grant = !rst && ((state_q == ST_IDLE) || rsp_ready);

   add_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
      .req_i       (req_valid & {N_REQ{can_grant}}),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .gnt_id_o    (gnt_id),
      .gnt_valid_o (gnt_valid)
   );

   assign req_ready = gnt;

   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            a_sel   = req_a[i*DATA_W +: DATA_W];
            b_sel   = req_b[i*DATA_W +: DATA_W];
            cin_sel = req_cin[i];
         end
      end
   end

   add_cba_adder u_add (
      .a_i    (a_sel),
      .b_i    (b_sel),
      .cin_i  (cin_sel),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   assign add_ovf = (a_sel[DATA_W-1] == b_sel[DATA_W-1]) &&
                    (add_sum[DATA_W-1] != a_sel[DATA_W-1]);

`ifdef ADD_ARBITER_SAT_EN
   assign sum_fin = add_ovf ? (a_sel[DATA_W-1] ? SAT_MIN : SAT_MAX) : add_sum;
`else
   assign sum_fin = add_sum;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (gnt_valid) begin
         state_d = ST_FULL;
         ptr_d   = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      end else if (state_q == ST_FULL && rsp_ready) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (gnt_valid) begin
            id_q   <= gnt_id;
            sum_q  <= sum_fin;
            cout_q <= add_cout;
            ovf_q  <= add_ovf;
         end
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - directed and random checks of add_arbiter against a behavioural model
module tb_add_arbiter;

   localparam int N  = 4;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [32*N-1:0] req_a, req_b;
   logic [N-1:0]  req_cin;
   logic          rsp_valid, rsp_ready;
   logic [IW-1:0] rsp_id;
   logic [31:0]   rsp_sum;
   logic          rsp_cout, rsp_ovf;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   bit          m_full;
   int          m_ptr;
   int          m_id;
   logic [31:0] m_sum;
   bit          m_cout, m_ovf;
   int          m_gnt;

   always #5 clk = ~clk;

   add_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 0; m_ptr = 0; m_id = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
   endtask

   // Sample at the falling edge: compute the expected grant and compare all outputs.
   task automatic settle();
      @(negedge clk);
      if (rst || (m_full && !rsp_ready)) m_gnt = -1;
      else m_gnt = pick(req_valid, m_ptr);
      chk("req_ready", 64'(req_ready), (m_gnt < 0) ? 64'd0 : 64'(1) << m_gnt);
      chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
      chk("rsp_sum",   64'(rsp_sum),   64'(m_sum));
      chk("rsp_cout",  64'(rsp_cout),  64'(m_cout));
      chk("rsp_ovf",   64'(rsp_ovf),   64'(m_ovf));
      chk("rsp_id",    64'(rsp_id),    64'(m_id));
   endtask

   task automatic advance();
      logic [31:0] a, b;
      logic [32:0] full_sum;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (m_gnt >= 0) begin
         a = req_a[m_gnt*32 +: 32];
         b = req_b[m_gnt*32 +: 32];
         full_sum = {1'b0, a} + {1'b0, b} + 33'(req_cin[m_gnt]);
         m_sum  = full_sum[31:0];
         m_cout = full_sum[32];
         m_ovf  = (a[31] == b[31]) && (full_sum[31] != a[31]);
`ifdef ADD_ARBITER_SAT_EN
         if (m_ovf) m_sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
         m_id   = m_gnt;
         m_full = 1;
         m_ptr  = (m_gnt + 1) % N;
      end else if (m_full && rsp_ready) begin
         m_full = 0;
      end
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_cin[i] = c;
   endtask

   initial begin
      logic [31:0] ovf_exp;
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      // reset state
      settle(); advance();
      rst = 1'b0;
      settle(); advance();

      // single op on requester 0
      set_op(0, 32'd5, 32'd7, 1'b1);
      req_valid = 4'b0001; rsp_ready = 1'b1;
      settle();
      chk("single_ready", 64'(req_ready), 64'h1);
      advance();
      req_valid = '0;
      settle();
      chk("single_sum", 64'(rsp_sum), 64'd13);
      chk("single_id", 64'(rsp_id), 64'd0);
      advance();

      // all requesting with continuous drain: grants 0,1,2,3,0
      rst = 1'b1; settle(); advance(); rst = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, 32'(i * 100), 32'(i + 1), 1'b0);
      req_valid = 4'b1111; rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         settle();
         chk("rr_grant", 64'(req_ready), 64'(1) << (g % N));
         if (g > 0) chk("rr_thru", 64'(rsp_valid), 64'd1);
         advance();
      end

      // backpressure for three cycles, then release
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("bp_ready", 64'(req_ready), 64'd0);
         advance();
      end
      rsp_ready = 1'b1;
      settle();
      chk("bp_release", 64'(req_ready), 64'h2);
      advance();

      // overflow and carry corners on requester 2
      rst = 1'b1; req_valid = '0; settle(); advance(); rst = 1'b0;
      set_op(2, 32'h7FFF_FFFF, 32'h1, 1'b0);
      req_valid = 4'b0100;
      settle(); advance();
      set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`ifdef ADD_ARBITER_SAT_EN
      ovf_exp = 32'h7FFF_FFFF;
`else
      ovf_exp = 32'h8000_0000;
`endif
      settle();
      chk("ovf_flag", 64'(rsp_ovf), 64'd1);
      chk("ovf_sum", 64'(rsp_sum), 64'(ovf_exp));
      advance();
      req_valid = '0;
      settle();
      chk("neg_sum", 64'(rsp_sum), 64'hFFFF_FFFE);
      chk("neg_cout", 64'(rsp_cout), 64'd1);
      advance();

      // reset while FULL discards the result, pointer returns to 0
      set_op(3, 32'd1, 32'd2, 1'b0);
      req_valid = 4'b1000; rsp_ready = 1'b0;
      settle(); advance();
      settle(); advance();
      rst = 1'b1;
      settle();
      chk("rst_ready", 64'(req_ready), 64'd0);
      advance();
      rst = 1'b0; req_valid = 4'b1010;
      settle();
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_first", 64'(req_ready), 64'h2);
      advance();

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         req_valid = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0: set_op(i, 32'h7FFF_FFFF, 32'($urandom_range(0, 2)), 1'($urandom));
               1: set_op(i, 32'h8000_0000, 32'hFFFF_FFFF - 32'($urandom_range(0, 2)), 1'($urandom));
               default: set_op(i, $urandom, $urandom, 1'($urandom));
            endcase
         end
         settle(); advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
